// File: rtl/iq_symbol_rx_pkg.sv
// Shared types, widths and helpers for the oversampled I/Q symbol receiver.
package iq_rx_pkg;

  localparam int SAMPLE_W = 5;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    MOD_BPSK  = 2'b00,
    MOD_QPSK  = 2'b01,
    MOD_QAM16 = 2'b10,
    MOD_OFF   = 2'b11
  } mod_sel_e;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } rx_state_e;

  function automatic logic [2:0] bitsPerSym(mod_sel_e modSel);
    logic [2:0] bps;
    case (modSel)
      MOD_BPSK:  bps = 3'd1;
      MOD_QPSK:  bps = 3'd2;
      MOD_QAM16: bps = 3'd4;
      default:   bps = 3'd0;
    endcase
    return bps;
  endfunction

endpackage

// File: rtl/iq_symbol_rx_if.sv
// Sample-in / nibble-out bundle between the I/Q pins, the receiver and the data path.
interface iq_symbol_rx_if;
  import iq_rx_pkg::*;

  logic [SAMPLE_W-1:0] i_in;
  logic [SAMPLE_W-1:0] q_in;
  logic                sample_en;
  logic [1:0]          mod_sel;
  logic [NIBBLE_W-1:0] data_o;
  logic                data_valid_o;
  logic                locked_o;

  modport master (
    output i_in,
    output q_in,
    output sample_en,
    output mod_sel,
    input  data_o,
    input  data_valid_o,
    input  locked_o
  );

  modport slave (
    input  i_in,
    input  q_in,
    input  sample_en,
    input  mod_sel,
    output data_o,
    output data_valid_o,
    output locked_o
  );

endinterface

// File: rtl/iq_symbol_rx_integrate_dump.sv
// Integrate-and-dump for both I and Q axes sharing one symbol phase counter.
// The sums presented on iSum_o/qSum_o already include the current sample.
module iq_integrate_dump
  import iq_rx_pkg::*;
#(
  parameter int OSR = 4,
  parameter int AW  = SAMPLE_W + $clog2(OSR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] iSample_i,
  input  logic [SAMPLE_W-1:0] qSample_i,
  output logic                dump_o,
  output logic [AW-1:0]       iSum_o,
  output logic [AW-1:0]       qSum_o
);

  localparam int PW = $clog2(OSR);
  localparam logic [PW-1:0] LAST_PHASE = PW'(OSR - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] accI_q, accI_d;
  logic [AW-1:0] accQ_q, accQ_d;
  logic [AW-1:0] iExt, qExt;

  assign iExt   = {{(AW - SAMPLE_W){iSample_i[SAMPLE_W-1]}}, iSample_i};
  assign qExt   = {{(AW - SAMPLE_W){qSample_i[SAMPLE_W-1]}}, qSample_i};
  assign iSum_o = accI_q + iExt;
  assign qSum_o = accQ_q + qExt;
  assign dump_o = en_i && (phase_q == LAST_PHASE);

  always_comb begin
    phase_d = phase_q;
    accI_d  = accI_q;
    accQ_d  = accQ_q;
    if (clear_i) begin
      phase_d = '0;
      accI_d  = '0;
      accQ_d  = '0;
    end else if (en_i) begin
      if (phase_q == LAST_PHASE) begin
        phase_d = '0;
        accI_d  = '0;
        accQ_d  = '0;
      end else begin
        phase_d = phase_q + PW'(1);
        accI_d  = iSum_o;
        accQ_d  = qSum_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      accI_q  <= '0;
      accQ_q  <= '0;
    end else begin
      phase_q <= phase_d;
      accI_q  <= accI_d;
      accQ_q  <= accQ_d;
    end
  end

endmodule

// File: rtl/iq_symbol_rx.sv
// Oversampled I/Q symbol receiver: acquisition, per-symbol slicing, nibble packing
// and loss-of-signal detection on top of a shared integrate-and-dump.
module iq_symbol_rx
  import iq_rx_pkg::*;
#(
  parameter int OSR          = 4,
  parameter int THR          = 4,
  parameter int SILENCE_SYMS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  iq_symbol_rx_if.slave bus
);

  localparam int AW = SAMPLE_W + $clog2(OSR);
  localparam int SW = $clog2(SILENCE_SYMS + 1);
  localparam logic [AW:0]       QAM_LIM  = (AW + 1)'(THR * OSR);
  localparam logic [AW:0]       SIL_LIM  = (AW + 1)'(THR * OSR / 2);
  localparam logic [SAMPLE_W:0] ACQ_LIM  = (SAMPLE_W + 1)'(THR);
  localparam logic [SW-1:0]     SIL_LAST = SW'(SILENCE_SYMS - 1);

  rx_state_e           state_q, state_d;
  logic [1:0]          modPrev_q;
  logic [NIBBLE_W-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic [NIBBLE_W-1:0] shift_q, shift_d;
  logic [2:0]          bitCnt_q, bitCnt_d;
  logic [SW-1:0]       silCnt_q, silCnt_d;

  mod_sel_e            modSel;
  logic                modeChange;
  logic                acquire;
  logic                accEn;
  logic                accClear;
  logic                dump;
  logic [AW-1:0]       sumI, sumQ;
  logic [SAMPLE_W:0]   iInX, iInAbs;
  logic [AW:0]         sumIx, sumQx, absI, absQ;
  logic                sI, sQ, mI, mQ, silent;
  logic [2:0]          bps, bitSum;
  logic [NIBBLE_W-1:0] nibble;

  assign modSel     = mod_sel_e'(bus.mod_sel);
  assign modeChange = (bus.mod_sel != modPrev_q);

  assign iInX    = {bus.i_in[SAMPLE_W-1], bus.i_in};
  assign iInAbs  = iInX[SAMPLE_W] ? (~iInX + (SAMPLE_W + 1)'(1)) : iInX;
  assign acquire = (state_q == HUNT) && bus.sample_en && (modSel != MOD_OFF)
                   && (iInAbs >= ACQ_LIM);

  // The acquiring sample is phase 0 of the first symbol, so it feeds the integrator.
  assign accEn    = bus.sample_en && !modeChange && ((state_q == LOCK) || acquire);
  assign accClear = modeChange;

  iq_integrate_dump #(
    .OSR (OSR),
    .AW  (AW)
  ) u_intDump (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accClear),
    .en_i      (accEn),
    .iSample_i (bus.i_in),
    .qSample_i (bus.q_in),
    .dump_o    (dump),
    .iSum_o    (sumI),
    .qSum_o    (sumQ)
  );

  // One extra bit so that |-16*OSR| is representable.
  assign sumIx  = {sumI[AW-1], sumI};
  assign sumQx  = {sumQ[AW-1], sumQ};
  assign absI   = sumIx[AW] ? (~sumIx + (AW + 1)'(1)) : sumIx;
  assign absQ   = sumQx[AW] ? (~sumQx + (AW + 1)'(1)) : sumQx;
  assign sI     = sumI[AW-1];
  assign sQ     = sumQ[AW-1];
  assign mI     = (absI < QAM_LIM);
  assign mQ     = (absQ < QAM_LIM);
  assign silent = (absI < SIL_LIM) && (absQ < SIL_LIM);

  assign bps    = bitsPerSym(modSel);
  assign bitSum = bitCnt_q + bps;

  always_comb begin
    case (modSel)
      MOD_BPSK:  nibble = {shift_q[2:0], sI};
      MOD_QPSK:  nibble = {shift_q[1:0], sI, sQ};
      MOD_QAM16: nibble = {sI, mI, sQ, mQ};
      default:   nibble = shift_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    silCnt_d = silCnt_q;
    if (modeChange) begin
      state_d  = HUNT;
      shift_d  = '0;
      bitCnt_d = '0;
      silCnt_d = '0;
    end else if (state_q == HUNT) begin
      if (acquire) begin
        state_d = LOCK;
      end
    end else if (dump) begin
      if (bitSum >= 3'd4) begin
        data_d   = nibble;
        valid_d  = 1'b1;
        shift_d  = '0;
        bitCnt_d = '0;
      end else begin
        shift_d  = nibble;
        bitCnt_d = bitSum;
      end
      // A nibble completed by the last silent symbol still goes out before lock drops.
      if (silent) begin
        if (silCnt_q == SIL_LAST) begin
          state_d  = HUNT;
          shift_d  = '0;
          bitCnt_d = '0;
          silCnt_d = '0;
        end else begin
          silCnt_d = silCnt_q + SW'(1);
        end
      end else begin
        silCnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    modPrev_q <= bus.mod_sel;
    if (!rst_n) begin
      state_q  <= HUNT;
      data_q   <= '0;
      valid_q  <= 1'b0;
      shift_q  <= '0;
      bitCnt_q <= '0;
      silCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      silCnt_q <= silCnt_d;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.data_valid_o = valid_q;
  assign bus.locked_o     = (state_q == LOCK);

endmodule

// File: tb/tb_iq_symbol_rx.sv
// Directed bench for iq_symbol_rx with OSR=4, THR=4, SILENCE_SYMS=4.
module tb_iq_symbol_rx;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  iq_symbol_rx_if bus ();

  iq_symbol_rx #(
    .OSR          (4),
    .THR          (4),
    .SILENCE_SYMS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are read 1 ns after the consuming rising edge.
  task automatic applyStimulus(input int iv, input int qv, input logic en);
    @(negedge clk);
    bus.i_in      = 5'(iv);
    bus.q_in      = 5'(qv);
    bus.sample_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input logic [1:0] mode);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mod_sel   = mode;
    bus.sample_en = 1'b0;
    bus.i_in      = '0;
    bus.q_in      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    bus.mod_sel = 2'b10;
    rst_n       = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(-6, 2, 1'b1);
      checks++;
      if ({bus.locked_o, bus.data_valid_o, bus.data_o} !== 6'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold: got locked/valid/data=%b required 000000",
                 {bus.locked_o, bus.data_valid_o, bus.data_o});
      end
    end
  endtask

  task automatic test_qam16;
    resetDut(2'b10);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(-6, 2, 1'b1);
      checks++;
      if (bus.locked_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL qam_locked s%0d: got %b required 1", k, bus.locked_o);
      end
      checks++;
      if (bus.data_valid_o !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL qam_valid s%0d: got %b required %b", k, bus.data_valid_o, (k == 4));
      end
    end
    checks++;
    if (bus.data_o !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL qam_data: got %b required 1001", bus.data_o);
    end
    applyStimulus(0, 0, 1'b0);
    checks++;
    if ({bus.data_valid_o, bus.data_o} !== 5'b0_1001) begin
      errors++;
      $display("[TB] FAIL qam_pulse_once: got valid/data=%b required 01001",
               {bus.data_valid_o, bus.data_o});
    end
  endtask

  task automatic test_bpsk;
    int symI [4];
    symI = '{6, -6, -6, 6};
    resetDut(2'b00);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(symI[(k - 1) / 4], 0, 1'b1);
      checks++;
      if (bus.data_valid_o !== (k == 16)) begin
        errors++;
        $display("[TB] FAIL bpsk_valid s%0d: got %b required %b", k, bus.data_valid_o, (k == 16));
      end
    end
    checks++;
    if (bus.data_o !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL bpsk_data: got %b required 0110", bus.data_o);
    end
  endtask

  task automatic test_qpsk_gaps;
    resetDut(2'b01);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus((k <= 4) ? -6 : 6, (k <= 4) ? 6 : -6, 1'b1);
      if (k == 1) begin
        checks++;
        if (bus.locked_o !== 1'b1) begin
          errors++;
          $display("[TB] FAIL qpsk_locked: got %b required 1", bus.locked_o);
        end
      end
      checks++;
      if (bus.data_valid_o !== (k == 8)) begin
        errors++;
        $display("[TB] FAIL qpsk_valid s%0d: got %b required %b", k, bus.data_valid_o, (k == 8));
      end
      applyStimulus(15, -16, 1'b0);
      checks++;
      if (bus.data_valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL qpsk_gap_valid g%0d: got %b required 0", k, bus.data_valid_o);
      end
    end
    checks++;
    if (bus.data_o !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL qpsk_data: got %b required 1001", bus.data_o);
    end
  endtask

  task automatic test_silence;
    resetDut(2'b10);
    for (int k = 1; k <= 4; k++) applyStimulus(-6, 2, 1'b1);
    checks++;
    if ({bus.data_valid_o, bus.data_o} !== 5'b1_1001) begin
      errors++;
      $display("[TB] FAIL sil_first_sym: got valid/data=%b required 11001",
               {bus.data_valid_o, bus.data_o});
    end
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 0, 1'b1);
      checks++;
      if (bus.data_valid_o !== (k % 4 == 0)) begin
        errors++;
        $display("[TB] FAIL sil_valid z%0d: got %b required %b", k, bus.data_valid_o, (k % 4 == 0));
      end
      if (k % 4 == 0) begin
        checks++;
        if (bus.data_o !== 4'b0101) begin
          errors++;
          $display("[TB] FAIL sil_data z%0d: got %b required 0101", k, bus.data_o);
        end
      end
      checks++;
      if (bus.locked_o !== (k < 16)) begin
        errors++;
        $display("[TB] FAIL sil_locked z%0d: got %b required %b", k, bus.locked_o, (k < 16));
      end
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus((k % 2 == 0) ? 3 : -3, 0, 1'b1);
      checks++;
      if ({bus.locked_o, bus.data_valid_o} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL sil_no_relock w%0d: got locked/valid=%b required 00", k,
                 {bus.locked_o, bus.data_valid_o});
      end
    end
  endtask

  task automatic test_reset_mid;
    resetDut(2'b10);
    applyStimulus(-6, 2, 1'b1);
    applyStimulus(-6, 2, 1'b1);
    rst_n = 1'b0;
    applyStimulus(-6, 2, 1'b1);
    checks++;
    if ({bus.locked_o, bus.data_valid_o, bus.data_o} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b required 000000",
               {bus.locked_o, bus.data_valid_o, bus.data_o});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(-6, 2, 1'b1);
      checks++;
      if (bus.data_valid_o !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL midreset_valid s%0d: got %b required %b", k, bus.data_valid_o, (k == 4));
      end
    end
  endtask

  task automatic test_mode_change;
    int symI [6];
    symI = '{6, -6, -6, 6, 6, -6};
    resetDut(2'b00);
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(symI[(k - 1) / 4], 0, 1'b1);
      checks++;
      if (bus.data_valid_o !== (k == 16)) begin
        errors++;
        $display("[TB] FAIL mc_bpsk_valid s%0d: got %b required %b", k, bus.data_valid_o, (k == 16));
      end
    end
    bus.mod_sel = 2'b01;
    applyStimulus(0, 0, 1'b0);
    checks++;
    if ({bus.locked_o, bus.data_valid_o, bus.data_o} !== 6'b00_0110) begin
      errors++;
      $display("[TB] FAIL mc_drop: got locked/valid/data=%b required 000110",
               {bus.locked_o, bus.data_valid_o, bus.data_o});
    end
    for (int k = 1; k <= 8; k++) begin
      applyStimulus((k <= 4) ? 6 : -6, (k <= 4) ? 6 : -6, 1'b1);
      checks++;
      if (bus.data_valid_o !== (k == 8)) begin
        errors++;
        $display("[TB] FAIL mc_qpsk_valid s%0d: got %b required %b", k, bus.data_valid_o, (k == 8));
      end
    end
    checks++;
    if (bus.data_o !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL mc_qpsk_data: got %b required 0011", bus.data_o);
    end
    bus.mod_sel = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(6, 6, 1'b1);
      checks++;
      if ({bus.locked_o, bus.data_valid_o} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL mc_off_nolock s%0d: got locked/valid=%b required 00", k,
                 {bus.locked_o, bus.data_valid_o});
      end
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.mod_sel   = 2'b10;
    bus.sample_en = 1'b0;
    bus.i_in      = '0;
    bus.q_in      = '0;
    test_reset();
    test_qam16();
    test_bpsk();
    test_qpsk_gaps();
    test_silence();
    test_reset_mid();
    test_mode_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
